// File: rtl/h264_coretransform.sv
// H.264 4x4 forward integer core transform, Y = Cf * X * CfT.
//
// Rows of four 9-bit residuals are accepted one at a time. The horizontal
// butterfly of each row is registered one cycle after that row is captured.
// Once the fourth row's result is stored, the sixteen coefficients are
// streamed out in raster order, one per cycle. Each coefficient is produced
// by a vertical butterfly over one column of the stored horizontal results,
// and the result is saturated to 14 bits.
//
// Ports
//   CLK    in   rising-edge clock
//   RESET  in   asynchronous active-low reset
//   ENABLE in   row strobe; XXIN is taken when ENABLE && READY
//   XXIN   in   {x3,x2,x1,x0}, 9-bit two's complement each
//   READY  out  block is accepting rows
//   VALID  out  YNOUT carries a coefficient this cycle
//   YNOUT  out  14-bit signed coefficient; holds its value while VALID=0
module h264_coretransform (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ENABLE,
  input  logic [35:0] XXIN,
  output logic        READY,
  output logic        VALID,
  output logic [13:0] YNOUT
);

  typedef enum logic [1:0] {S_CAP, S_WAIT, S_OUT} state_t;

  state_t state, state_nxt;

  logic              take;
  logic [1:0]        row_cnt;
  logic [3:0]        out_idx;     // {row, col} of the next coefficient
  logic [35:0]       xrow;        // captured row, waiting for its butterfly
  logic [1:0]        xrow_idx;
  logic              xrow_vld;
  logic [3:0][3:0][11:0] hmat;    // horizontal results, [row][col]
  logic [3:0][15:0]  hrow;
  logic [3:0][15:0]  vcol;
  logic signed [15:0] yraw;
  logic [13:0]       ysat;

  // 16 bits covers both stages: |H| <= 1533, |Y| <= 9198.
  function automatic logic [3:0][15:0] bfly(input logic signed [15:0] v0,
                                            input logic signed [15:0] v1,
                                            input logic signed [15:0] v2,
                                            input logic signed [15:0] v3);
    logic signed [15:0] a, b, c, d;
    logic [3:0][15:0]   r;
    a = v0 + v3;
    b = v1 + v2;
    c = v1 - v2;
    d = v0 - v3;
    r[0] = a + b;
    r[1] = (d <<< 1) + c;
    r[2] = a - b;
    r[3] = d - (c <<< 1);
    return r;
  endfunction

  function automatic logic signed [15:0] sx9(input logic [8:0] v);
    return {{7{v[8]}}, v};
  endfunction

  function automatic logic signed [15:0] sx12(input logic [11:0] v);
    return {{4{v[11]}}, v};
  endfunction

  assign take = ENABLE && READY;

  // ---------------- FSM ----------------
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= S_CAP;
    else        state <= state_nxt;
  end

  // S_WAIT covers the cycle in which the fourth row's butterfly is stored.
  always_comb begin
    state_nxt = state;
    case (state)
      S_CAP:   if (take && row_cnt == 2'd3) state_nxt = S_WAIT;
      S_WAIT:  state_nxt = S_OUT;
      S_OUT:   if (out_idx == 4'd15) state_nxt = S_CAP;
      default: state_nxt = S_CAP;
    endcase
  end

  always_comb begin
    READY = (state == S_CAP);
  end

  // ---------------- datapath ----------------
  always_comb begin
    hrow = bfly(sx9(xrow[8:0]), sx9(xrow[17:9]), sx9(xrow[26:18]), sx9(xrow[35:27]));
  end

  always_comb begin
    vcol = bfly(sx12(hmat[0][out_idx[1:0]]), sx12(hmat[1][out_idx[1:0]]),
                sx12(hmat[2][out_idx[1:0]]), sx12(hmat[3][out_idx[1:0]]));
    yraw = $signed(vcol[out_idx[3:2]]);
    if (yraw > 16'sd8191)       ysat = 14'h1fff;
    else if (yraw < -16'sd8192) ysat = 14'h2000;
    else                        ysat = yraw[13:0];
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      row_cnt  <= '0;
      out_idx  <= '0;
      xrow     <= '0;
      xrow_idx <= '0;
      xrow_vld <= 1'b0;
      hmat     <= '0;
      VALID    <= 1'b0;
      YNOUT    <= '0;
    end else begin
      xrow_vld <= take;
      if (take) begin
        xrow     <= XXIN;
        xrow_idx <= row_cnt;
        row_cnt  <= row_cnt + 2'd1;   // wraps to 0 on the fourth row
      end
      if (xrow_vld) begin
        for (int j = 0; j < 4; j++) hmat[xrow_idx][j] <= hrow[j][11:0];
      end
      VALID <= (state == S_OUT);
      if (state == S_OUT) begin
        YNOUT   <= ysat;
        out_idx <= out_idx + 4'd1;    // wraps to 0 after the last coefficient
      end
    end
  end

endmodule

// File: tb/tb_h264_coretransform.sv
// Directed bench for h264_coretransform: exact latency, raster order,
// saturation, ENABLE gaps, input blocking during output, and reset abandon.
module tb_h264_coretransform;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        ENABLE;
  logic [35:0] XXIN;
  logic        READY;
  logic        VALID;
  logic [13:0] YNOUT;

  int checks = 0;
  int failures = 0;
  int exp_y[16];

  h264_coretransform dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .XXIN(XXIN),
    .READY(READY), .VALID(VALID), .YNOUT(YNOUT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [35:0] mkrow(input int x0, input int x1, input int x2, input int x3);
    logic [8:0] a, b, c, d;
    a = 9'(x0); b = 9'(x1); c = 9'(x2); d = 9'(x3);
    return {d, c, b, a};
  endfunction

  // One row captured at the next rising edge; returns 1 time unit after it.
  task automatic put_row(input logic [35:0] v);
    @(negedge CLK);
    ENABLE = 1'b1;
    XXIN   = v;
    @(posedge CLK);
    #1 ENABLE = 1'b0;
  endtask

  // Called right after the edge that took the 4th row (edge k).
  task automatic collect(input string tag);
    @(negedge CLK);
    chk({tag, " k valid"}, int'(VALID), 0);
    chk({tag, " k ready"}, int'(READY), 0);
    @(negedge CLK);
    chk({tag, " k+1 valid"}, int'(VALID), 0);
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      chk($sformatf("%s y%0d valid", tag, i), int'(VALID), 1);
      chk($sformatf("%s y%0d", tag, i), int'($signed(YNOUT)), exp_y[i]);
      if (i < 15) chk($sformatf("%s y%0d ready", tag, i), int'(READY), 0);
    end
    @(negedge CLK);
    chk({tag, " end valid"}, int'(VALID), 0);
    chk({tag, " end ready"}, int'(READY), 1);
  endtask

  task automatic set_exp_dc(input int y00, input int y01, input int y02, input int y03);
    for (int i = 0; i < 16; i++) exp_y[i] = 0;
    exp_y[0] = y00; exp_y[1] = y01; exp_y[2] = y02; exp_y[3] = y03;
  endtask

  initial begin
    logic [35:0] r23, rmax, rsa, rsb;
    int bad;
    r23  = mkrow(15, -17, -32, 170);
    rmax = mkrow(255, 255, 255, 255);
    rsa  = mkrow(255, 255, -256, -256);
    rsb  = mkrow(-256, -256, 255, 255);

    ENABLE = 1'b0;
    XXIN   = '0;
    RESET  = 1'b0;
    #12;
    chk("rst ready", int'(READY), 1);
    chk("rst valid", int'(VALID), 0);
    chk("rst ynout", int'(YNOUT), 0);
    @(negedge CLK);
    RESET = 1'b1;

    // basic block, four identical rows back to back
    set_exp_dc(544, -1180, 936, -740);
    repeat (4) put_row(r23);
    collect("basic");

    // all-zero block
    set_exp_dc(0, 0, 0, 0);
    repeat (4) put_row('0);
    collect("zero");

    // all-255 block
    set_exp_dc(4080, 0, 0, 0);
    repeat (4) put_row(rmax);
    collect("max");

    // saturation: Y[1][1] raw 9198
    for (int i = 0; i < 16; i++) exp_y[i] = 0;
    exp_y[0] = -8; exp_y[5] = 8191; exp_y[7] = -3066;
    exp_y[13] = -3066; exp_y[15] = 1022;
    put_row(rsa); put_row(rsa); put_row(rsb); put_row(rsb);
    collect("sat");

    // gapped rows, then ENABLE held high through the output phase
    set_exp_dc(544, -1180, 936, -740);
    put_row(r23);
    repeat (3) @(posedge CLK);
    repeat (3) put_row(r23);
    ENABLE = 1'b1;
    XXIN   = rmax;
    collect("gap");
    // edge k+18 took the first held row; three more complete the block
    repeat (3) @(posedge CLK);
    #1 ENABLE = 1'b0;
    set_exp_dc(4080, 0, 0, 0);
    collect("held");

    // only two rows: nothing comes out
    put_row(r23);
    put_row(r23);
    bad = 0;
    repeat (30) begin
      @(negedge CLK);
      if (VALID !== 1'b0 || READY !== 1'b1) bad++;
    end
    chk("partial idle", bad, 0);

    // reset abandons the partial block; a fresh block starts at row 0
    @(negedge CLK);
    RESET = 1'b0;
    #2 RESET = 1'b1;
    set_exp_dc(544, -1180, 936, -740);
    repeat (4) put_row(r23);
    collect("after rst");

    // reset during output
    set_exp_dc(4080, 0, 0, 0);
    repeat (4) put_row(rmax);
    repeat (8) @(negedge CLK);
    chk("pre rst valid", int'(VALID), 1);
    #2 RESET = 1'b0;
    #1;
    chk("mid rst valid", int'(VALID), 0);
    chk("mid rst ready", int'(READY), 1);
    chk("mid rst ynout", int'(YNOUT), 0);
    @(negedge CLK);
    RESET = 1'b1;
    bad = 0;
    repeat (25) begin
      @(negedge CLK);
      if (VALID !== 1'b0 || READY !== 1'b1) bad++;
    end
    chk("post rst idle", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
